// File: rtl/cg_multi_ctrl.sv
// cg_multi_ctrl: multi-channel clock-gating controller.
// Each channel has a glitch-free gated clock built from a low-transparent
// enable latch and an AND gate. A per-channel FSM gates the channel after a
// programmable run of idle cycles. It restarts the clock on demand and
// reports ch_ready after a fixed wake latency.
// Optional feature: define CG_STATS_EN to add per-channel saturating
// gated-cycle counters that are readable through stat_sel/stat_cnt.
module cg_multi_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_LAT = 2,
    parameter int STAT_W   = 16,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     ck_in,
    input  logic                     rst_n,
    input  logic                     test,
    input  logic [NUM_CH-1:0]        ch_busy,
    input  logic [NUM_CH*IDLE_W-1:0] idle_thr,
    output logic [NUM_CH-1:0]        ck_out,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic [NUM_CH-1:0]        ch_gated,
    input  logic [SEL_W-1:0]         stat_sel,
    input  logic                     stat_clr,
    output logic [STAT_W-1:0]        stat_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    // wake_cnt value on which the WAKE state hands over to RUN
    localparam logic [3:0] WAKE_LAST = (WAKE_LAT > 0) ? 4'(WAKE_LAT - 1) : 4'd0;

`ifdef CG_STATS_EN
    logic [STAT_W-1:0] stat_arr [NUM_CH];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t            state_reg, state_next;
            logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
            logic [3:0]        wake_cnt_reg, wake_cnt_next;
            logic              en_reg, en_next;
            logic              ready_reg, ready_next;
            logic              gated_reg, gated_next;
            logic              en_q;
            logic [IDLE_W-1:0] thr;
            logic [IDLE_W:0]   idle_inc;

            assign thr      = idle_thr[gi*IDLE_W +: IDLE_W];
            // One extra bit so the threshold compare cannot wrap at all-ones
            assign idle_inc = {1'b0, idle_cnt_reg} + (IDLE_W+1)'(1);

            // Channel state registers; reset leaves the clock running
            always_ff @(posedge ck_in or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg    <= ST_RUN;
                    idle_cnt_reg <= '0;
                    wake_cnt_reg <= '0;
                    en_reg       <= 1'b1;
                    ready_reg    <= 1'b1;
                    gated_reg    <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    idle_cnt_reg <= idle_cnt_next;
                    wake_cnt_reg <= wake_cnt_next;
                    en_reg       <= en_next;
                    ready_reg    <= ready_next;
                    gated_reg    <= gated_next;
                end
            end

            // Next-state logic: idle detection, gating and timed wake-up
            always_comb begin
                state_next    = state_reg;
                idle_cnt_next = idle_cnt_reg;
                wake_cnt_next = wake_cnt_reg;
                en_next       = en_reg;
                ready_next    = ready_reg;
                gated_next    = gated_reg;
                case (state_reg)
                    ST_RUN: begin
                        if (ch_busy[gi]) begin
                            idle_cnt_next = '0;
                        end else if (thr == '0) begin
                            // threshold 0 disables gating; counter holds
                            idle_cnt_next = idle_cnt_reg;
                        end else if (idle_inc >= {1'b0, thr}) begin
                            state_next = ST_GATED;
                            en_next    = 1'b0;
                            ready_next = 1'b0;
                            gated_next = 1'b1;
                        end else if (!(&idle_cnt_reg)) begin
                            idle_cnt_next = idle_inc[IDLE_W-1:0];
                        end
                    end
                    ST_GATED: begin
                        if (ch_busy[gi]) begin
                            en_next    = 1'b1;
                            gated_next = 1'b0;
                            if (WAKE_LAT > 0) begin
                                state_next    = ST_WAKE;
                                wake_cnt_next = '0;
                            end else begin
                                state_next    = ST_RUN;
                                ready_next    = 1'b1;
                                idle_cnt_next = '0;
                            end
                        end
                    end
                    ST_WAKE: begin
                        // busy is ignored here: a started wake always completes
                        wake_cnt_next = wake_cnt_reg + 4'd1;
                        if (wake_cnt_reg == WAKE_LAST) begin
                            state_next    = ST_RUN;
                            ready_next    = 1'b1;
                            idle_cnt_next = '0;
                        end
                    end
                    default: begin
                        state_next = ST_RUN;
                    end
                endcase
            end

            // Enable latch: transparent in the low phase so ck_out never glitches
            always_latch begin
                if (!ck_in) begin
                    en_q <= en_reg | test;
                end
            end

            assign ck_out[gi]   = ck_in & en_q;
            assign ch_ready[gi] = ready_reg;
            assign ch_gated[gi] = gated_reg;

`ifdef CG_STATS_EN
            logic [STAT_W-1:0] stat_reg;

            // Saturating count of edges spent in GATED; clear has priority
            always_ff @(posedge ck_in or negedge rst_n) begin
                if (!rst_n) begin
                    stat_reg <= '0;
                end else if (stat_clr) begin
                    stat_reg <= '0;
                end else if ((state_reg == ST_GATED) && !(&stat_reg)) begin
                    stat_reg <= stat_reg + STAT_W'(1);
                end
            end

            assign stat_arr[gi] = stat_reg;
`endif
        end
    endgenerate

`ifdef CG_STATS_EN
    // Read mux; selects beyond the channel count return zero
    always_comb begin
        stat_cnt = '0;
        if (int'(stat_sel) < NUM_CH) begin
            stat_cnt = stat_arr[stat_sel];
        end
    end
`else
    logic unused_stat;
    assign unused_stat = ^{stat_sel, stat_clr};
    assign stat_cnt    = '0;
`endif

endmodule
